// File: rtl/hram_test_pkg.sv
// Shared definitions for the HyperRAM test master: FSM state codes,
// pattern-mode codes, LFSR constants and the LFSR step function.
package hram_test_pkg;

  localparam int unsigned DATA_W = 16;

  // FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD_REQ  = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // Pattern modes, selected by switches[1:0]
  typedef logic [1:0] pat_mode_t;
  localparam pat_mode_t PAT_ADDR  = 2'd0;
  localparam pat_mode_t PAT_INV   = 2'd1;
  localparam pat_mode_t PAT_WALK1 = 2'd2;
  localparam pat_mode_t PAT_LFSR  = 2'd3;

  // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return {1'b0, s[DATA_W-1:1]} ^ (s[0] ? LFSR_TAPS : {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/avs_hram_test_master_if.sv
// Avalon-MM bus between the test master and the HyperRAM converter.
//   address/read/write/writedata/byteenable : master -> slave
//   readdata/readdatavalid/waitrequest      : slave -> master
interface avs_hram_test_master_if
  import hram_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 22
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [1:0]        byteenable;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/hram_pattern_gen.sv
// Test-pattern generator. Holds the pattern for the current word in a
// register; seed loads the pattern for word 0, step advances to the next
// word. The caller presents the mode and index that apply after the update.
//   clk, reset_n : clock, async active-low reset
//   mode         : pattern mode
//   index        : word offset the updated pattern is for
//   seed, step   : reload / advance strobes (seed wins)
//   pattern_q    : registered pattern for the current word
module hram_pattern_gen
  import hram_test_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  pat_mode_t         mode,
  input  logic [15:0]       index,
  input  logic              seed,
  input  logic              step,
  output logic [DATA_W-1:0] pattern_q
);

  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_d;
  logic [DATA_W-1:0] pattern_d;

  // Next LFSR value and the pattern it implies for the new index
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed) begin
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
    case (mode)
      PAT_ADDR:  pattern_d = index;
      PAT_INV:   pattern_d = ~index;
      PAT_WALK1: pattern_d = DATA_W'(16'h0001) << index[3:0];
      default:   pattern_d = lfsr_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q    <= LFSR_SEED;
      pattern_q <= '0;
    end else if (seed || step) begin
      lfsr_q    <= lfsr_d;
      pattern_q <= pattern_d;
    end
  end

endmodule

// File: rtl/avs_hram_test_master.sv
// Switch-driven Avalon-MM test master for the HyperRAM converter.
// A rising edge on switches[3] writes N_WORDS words of the selected pattern
// from BASE_ADDR, then reads them back one at a time and compares.
//   clk, reset_n   : clock, async active-low reset
//   switches       : [3] start (async level), [1:0] pattern mode
//   leds           : [0] busy, [1] done, [2] pass, [3] fail
//   avm            : Avalon-MM master port
//   err_count      : saturating mismatch count
//   first_err_addr : address of the first mismatch
//   timeout        : run aborted because the slave stalled too long
module avs_hram_test_master
  import hram_test_pkg::*;
#(
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned N_WORDS        = 256,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [3:0]                     switches,
  output logic [3:0]                     leds,
  avs_hram_test_master_if.master         avm,
  output logic [15:0]                    err_count,
  output logic [ADDR_W-1:0]              first_err_addr,
  output logic                           timeout
);

  localparam int unsigned IDX_W = (ADDR_W > 16) ? ADDR_W : 16;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              sw_meta_q, sw_sync_q, sw_prev_q;
  logic              start_c;
  logic              sw_unused_c;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pat_mode_t         mode_q, mode_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              tmo_q, tmo_d;
  logic [3:0]        leds_q, leds_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        be_q, be_d;

  logic              seed_c, step_c, last_c, tmo_hit_c, busy_c, pass_c;
  logic [DATA_W-1:0] pattern_q;

  assign sw_unused_c = switches[2];

  // Two-flop synchronizer plus edge-detect history for the start switch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      sw_prev_q <= 1'b0;
    end else begin
      sw_meta_q <= switches[3];
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
    end
  end

  assign start_c   = sw_sync_q & ~sw_prev_q;
  assign last_c    = (index_q == IDX_W'(N_WORDS - 1));
  assign tmo_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  hram_pattern_gen u_pattern_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode_d),
    .index     (index_d[15:0]),
    .seed      (seed_c),
    .step      (step_c),
    .pattern_q (pattern_q)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    tmo_d   = tmo_q;
    seed_c  = 1'b0;
    step_c  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_c) begin
          state_d = ST_WR;
          mode_d  = switches[1:0];
          index_d = '0;
          cnt_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          tmo_d   = 1'b0;
          seed_c  = 1'b1;
        end
      end

      ST_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (write_q && !avm.waitrequest) begin
          cnt_d = '0;
          if (last_c) begin
            // Rewind to word 0 for the read-back phase
            state_d = ST_RD_REQ;
            index_d = '0;
            seed_c  = 1'b1;
          end else begin
            index_d = index_q + IDX_W'(1);
            step_c  = 1'b1;
          end
        end else if (tmo_hit_c) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end
      end

      ST_RD_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (read_q && !avm.waitrequest) begin
          state_d = ST_RD_WAIT;
          cnt_d   = '0;
        end else if (tmo_hit_c) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end
      end

      ST_RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (avm.readdatavalid) begin
          cnt_d = '0;
          if (avm.readdata != pattern_q) begin
            if (err_q == 16'h0000) begin
              ferr_d = addr_q;
            end
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
          end
          if (last_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
            index_d = index_q + IDX_W'(1);
            step_c  = 1'b1;
          end
        end else if (tmo_hit_c) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_c  = (state_d == ST_WR) || (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT);
    pass_c  = (err_d == 16'h0000) && !tmo_d;
    write_d = (state_d == ST_WR);
    read_d  = (state_d == ST_RD_REQ);
    be_d    = (write_d || read_d) ? 2'b11 : 2'b00;
    addr_d  = busy_c ? (ADDR_W'(BASE_ADDR) + index_d[ADDR_W-1:0]) : '0;
    leds_d  = {(state_d == ST_DONE) && !pass_c,
               (state_d == ST_DONE) && pass_c,
               (state_d == ST_DONE),
               busy_c};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      cnt_q   <= '0;
      mode_q  <= PAT_ADDR;
      err_q   <= '0;
      ferr_q  <= '0;
      tmo_q   <= 1'b0;
      leds_q  <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
      leds_q  <= leds_d;
      write_q <= write_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  assign avm.address    = addr_q;
  assign avm.read       = read_q;
  assign avm.write      = write_q;
  assign avm.writedata  = pattern_q;
  assign avm.byteenable = be_q;
  assign leds           = leds_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_avs_hram_test_master.sv
// Directed bench for avs_hram_test_master with a small Avalon slave model
// (zero-wait writes, read latency 3) that can stall, corrupt or drop reads.
module tb_avs_hram_test_master;

  localparam int unsigned ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [3:0]        switches = 4'b0000;
  logic [3:0]        leds;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic              timeout;

  int n_cmp = 0;
  int n_bad = 0;

  avs_hram_test_master_if #(.ADDR_W(ADDR_W)) avm_if ();

  avs_hram_test_master #(
    .ADDR_W(ADDR_W), .N_WORDS(4), .BASE_ADDR(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .switches       (switches),
    .leds           (leds),
    .avm            (avm_if),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic        stall_arm = 1'b0;
  logic [ADDR_W-1:0] stall_addr = 17;
  int          stall_cnt = 0;
  logic        corrupt_arm = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = 18;
  logic        no_rdv = 1'b0;
  logic [15:0] mem [0:63];
  int          wr_acc = 0;
  logic [2:0]  rd_vld_pipe = 3'b000;
  logic [ADDR_W-1:0] rd_addr_pipe [0:2];

  assign avm_if.waitrequest = stall_arm && avm_if.write &&
                              (avm_if.address == stall_addr) && (stall_cnt < 5);
  assign avm_if.readdatavalid = rd_vld_pipe[2] && !no_rdv;
  assign avm_if.readdata = (corrupt_arm && rd_addr_pipe[2] == corrupt_addr) ?
                           16'hDEAD : mem[rd_addr_pipe[2][5:0]];

  always @(posedge clk) begin
    if (avm_if.write && !avm_if.waitrequest) begin
      mem[avm_if.address[5:0]] <= avm_if.writedata;
      wr_acc <= wr_acc + 1;
    end
    if (!stall_arm) stall_cnt <= 0;
    else if (avm_if.waitrequest) stall_cnt <= stall_cnt + 1;
    rd_vld_pipe     <= {rd_vld_pipe[1:0], avm_if.read && !avm_if.waitrequest};
    rd_addr_pipe[0] <= avm_if.address;
    rd_addr_pipe[1] <= rd_addr_pipe[0];
    rd_addr_pipe[2] <= rd_addr_pipe[1];
  end

  // Monitor of the stalled write at address 17
  int wr17_cycles = 0;
  int wr17_bad = 0;
  always @(negedge clk) begin
    if (avm_if.write && avm_if.address == 17) begin
      wr17_cycles <= wr17_cycles + 1;
      if (avm_if.writedata != 16'h0001 || avm_if.byteenable != 2'b11)
        wr17_bad <= wr17_bad + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] mode);
    @(negedge clk);
    switches = {2'b00, mode};
    repeat (4) @(negedge clk);
    switches = {2'b10, mode};
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (leds[0]) break;
    end
    check("busy_seen", 32'(leds[0]), 32'd1);
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (leds[1]) break;
    end
    check("done_seen", 32'(leds[1]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int acc0, c17, b17;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_write", 32'(avm_if.write), 32'h0);
    check("rst_read", 32'(avm_if.read), 32'h0);
    check("rst_be", 32'(avm_if.byteenable), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    check("rst_tmo", 32'(timeout), 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_leds", 32'(leds), 32'h0);

    // Run 1: mode 0, no stalls; check start latency
    acc0 = wr_acc;
    switches = 4'b1000;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (avm_if.write) begin n = i; break; end
    end
    check("start_latency", 32'(n), 32'd3);
    check("first_addr", 32'(avm_if.address), 32'd16);
    check("first_be", 32'(avm_if.byteenable), 32'h3);
    wait_done();
    check("r1_leds", 32'(leds), 32'b0110);
    check("r1_err", 32'(err_count), 32'h0);
    check("r1_mem16", 32'(mem[16]), 32'h0000);
    check("r1_mem17", 32'(mem[17]), 32'h0001);
    check("r1_mem18", 32'(mem[18]), 32'h0002);
    check("r1_mem19", 32'(mem[19]), 32'h0003);
    check("r1_wr_acc", 32'(wr_acc - acc0), 32'd4);
    check("r1_idle_be", 32'(avm_if.byteenable), 32'h0);

    // Run 2: 5-cycle stall on the second write
    stall_arm = 1'b1;
    acc0 = wr_acc; c17 = wr17_cycles; b17 = wr17_bad;
    start_run(2'd0);
    wait_done();
    check("r2_leds", 32'(leds), 32'b0110);
    check("r2_wr17_cycles", 32'(wr17_cycles - c17), 32'd6);
    check("r2_wr17_unstable", 32'(wr17_bad - b17), 32'd0);
    check("r2_wr_acc", 32'(wr_acc - acc0), 32'd4);
    stall_arm = 1'b0;

    // Run 3: walking one, start re-toggled while busy
    acc0 = wr_acc;
    start_run(2'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (leds[0]) break;
    end
    repeat (4) @(negedge clk);
    switches = 4'b0010;
    repeat (4) @(negedge clk);
    switches = 4'b1010;
    wait_done();
    check("r3_leds", 32'(leds), 32'b0110);
    check("r3_wr_acc", 32'(wr_acc - acc0), 32'd4);
    check("r3_mem16", 32'(mem[16]), 32'h0001);
    check("r3_mem17", 32'(mem[17]), 32'h0002);
    check("r3_mem18", 32'(mem[18]), 32'h0004);
    check("r3_mem19", 32'(mem[19]), 32'h0008);
    repeat (10) @(negedge clk);
    check("r3_stays_done", 32'(leds), 32'b0110);

    // Run 4: LFSR, read of address 18 corrupted
    corrupt_arm = 1'b1;
    start_run(2'd3);
    wait_done();
    check("r4_leds", 32'(leds), 32'b1010);
    check("r4_err", 32'(err_count), 32'd1);
    check("r4_first_err", 32'(first_err_addr), 32'd18);
    check("r4_tmo", 32'(timeout), 32'd0);
    check("r4_mem16", 32'(mem[16]), 32'hACE1);
    check("r4_mem17", 32'(mem[17]), 32'hE270);
    check("r4_mem18", 32'(mem[18]), 32'h7138);
    check("r4_mem19", 32'(mem[19]), 32'h389C);
    corrupt_arm = 1'b0;

    // Run 5: fresh run from DONE, mode 1, error state cleared
    start_run(2'd1);
    wait_done();
    check("r5_leds", 32'(leds), 32'b0110);
    check("r5_err", 32'(err_count), 32'd0);
    check("r5_first_err", 32'(first_err_addr), 32'd0);
    check("r5_mem16", 32'(mem[16]), 32'hFFFF);
    check("r5_mem19", 32'(mem[19]), 32'hFFFC);

    // Run 6: slave never returns read data -> timeout
    no_rdv = 1'b1;
    start_run(2'd0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm_if.read && !avm_if.waitrequest) begin n = 1; break; end
    end
    check("r6_read_seen", 32'(n), 32'd1);
    check("r6_read_addr", 32'(avm_if.address), 32'd16);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!leds[0]) break;
      n++;
    end
    check("r6_busy_cycles", 32'(n), 32'd32);
    check("r6_tmo", 32'(timeout), 32'd1);
    check("r6_leds", 32'(leds), 32'b1010);
    check("r6_read_low", 32'(avm_if.read), 32'd0);
    check("r6_err", 32'(err_count), 32'd0);
    no_rdv = 1'b0;

    // Run 7: reset asserted during the write phase
    start_run(2'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_if.write) break;
    end
    check("r7_in_write", 32'(avm_if.write), 32'd1);
    #2;
    reset_n  = 1'b0;
    switches = 4'b0000;
    #1;
    check("r7_rst_write", 32'(avm_if.write), 32'd0);
    check("r7_rst_leds", 32'(leds), 32'h0);
    check("r7_rst_tmo", 32'(timeout), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("r7_idle_leds", 32'(leds), 32'h0);
    check("r7_idle_write", 32'(avm_if.write), 32'd0);
    start_run(2'd0);
    wait_done();
    check("r7_leds", 32'(leds), 32'b0110);
    check("r7_err", 32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
